// File: rtl/operand_fetch.sv
// Operand fetch stage: 16-entry register file plus PSR, decodes an instruction into registered ALU operands.
// Optional feature macro OPERAND_BYPASS_EN forwards same-cycle write-back and PSR updates.
module operand_fetch #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic             stall,
  input  logic             wb_en,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       psr_wr_en,
  input  logic [4:0]       psr_wr,
  input  logic             psr_valid,
  output logic             op_valid,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] src,
  output logic [3:0]       oper,
  output logic [3:0]       func,
  output logic [3:0]       cond,
  output logic [4:0]       psr_read,
  output logic [3:0]       dst_addr
);

  localparam int unsigned NREG = 16;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [4:0]       psr_q, psr_d;
  logic             op_valid_q, op_valid_d;
  logic [WIDTH-1:0] dst_q, dst_d, src_q, src_d;
  logic [3:0]       oper_q, oper_d, func_q, func_d, cond_q, cond_d, dst_addr_q, dst_addr_d;

  logic [3:0]       rdest, rsrc, op_f, fn_f;
  logic [WIDTH-1:0] rd_dst, rd_src, sel_dst, sel_src;

  // Register file and PSR write-back
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (wb_en) regs_d[wb_addr] = wb_data;
    psr_d = psr_q;
    if (psr_valid) psr_d = (psr_q & ~psr_wr_en) | (psr_wr & psr_wr_en);
  end

  // Register reads with optional same-cycle forwarding
  always_comb begin
    op_f   = instr[15:12];
    rdest  = instr[11:8];
    fn_f   = instr[7:4];
    rsrc   = instr[3:0];
    rd_dst = regs_q[rdest];
    rd_src = regs_q[rsrc];
`ifdef OPERAND_BYPASS_EN
    if (wb_en && (wb_addr == rdest)) rd_dst = wb_data;
    if (wb_en && (wb_addr == rsrc))  rd_src = wb_data;
`endif
  end

  // Operand selection by opcode class
  always_comb begin
    sel_dst = rd_dst;
    sel_src = {{(WIDTH-8){instr[7]}}, instr[7:0]};
    case (op_f)
      4'b0000: sel_src = rd_src;
      4'b0001, 4'b0010, 4'b0011: sel_src = WIDTH'(instr[7:0]);
      4'b1000: sel_src = {{(WIDTH-5){instr[4]}}, instr[4:0]};
      4'b1100: sel_dst = pc;
      4'b0100: begin
        sel_src = rd_src;
        if (fn_f == 4'b1100) sel_dst = pc;
      end
      default: ;
    endcase
  end

  // Output register next-state: capture, empty cycle, or hold on stall
  always_comb begin
    op_valid_d = op_valid_q;
    dst_d      = dst_q;
    src_d      = src_q;
    oper_d     = oper_q;
    func_d     = func_q;
    cond_d     = cond_q;
    dst_addr_d = dst_addr_q;
    if (!stall) begin
      op_valid_d = instr_valid;
      if (instr_valid) begin
        dst_d      = sel_dst;
        src_d      = sel_src;
        oper_d     = op_f;
        func_d     = fn_f;
        cond_d     = rdest;
        dst_addr_d = rdest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      psr_q      <= '0;
      op_valid_q <= 1'b0;
      dst_q      <= '0;
      src_q      <= '0;
      oper_q     <= '0;
      func_q     <= '0;
      cond_q     <= '0;
      dst_addr_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      psr_q      <= psr_d;
      op_valid_q <= op_valid_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      oper_q     <= oper_d;
      func_q     <= func_d;
      cond_q     <= cond_d;
      dst_addr_q <= dst_addr_d;
    end
  end

  assign op_valid = op_valid_q;
  assign dst      = dst_q;
  assign src      = src_q;
  assign oper     = oper_q;
  assign func     = func_q;
  assign cond     = cond_q;
  assign dst_addr = dst_addr_q;
`ifdef OPERAND_BYPASS_EN
  assign psr_read = psr_d;
`else
  assign psr_read = psr_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, instr_valid, stall, wb_en, psr_valid;
  logic [15:0] instr, pc, wb_data;
  logic [3:0]  wb_addr;
  logic [4:0]  psr_wr_en, psr_wr;
  logic        op_valid;
  logic [15:0] dst, src;
  logic [3:0]  oper, func, cond, dst_addr;
  logic [4:0]  psr_read;

  int n_cmp = 0;
  int n_bad = 0;

  operand_fetch #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .psr_wr_en(psr_wr_en), .psr_wr(psr_wr), .psr_valid(psr_valid),
    .op_valid(op_valid), .dst(dst), .src(src), .oper(oper), .func(func),
    .cond(cond), .psr_read(psr_read), .dst_addr(dst_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; stall = 1'b0; wb_en = 1'b0; psr_valid = 1'b0;
    psr_wr_en = '0; psr_wr = '0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] i);
    instr_valid = 1'b1; instr = i;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    write_reg(4'd3, 16'h1234);
    issue(16'h0330);
    n_cmp++; if (dst !== 16'h1234) begin n_bad++; $display("FAIL pre_reset_dst: got %h want 1234", dst); end
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_cmp++; if ({op_valid, dst, src, oper, func, cond, dst_addr, psr_read} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: op_valid=%b dst=%h src=%h oper=%h func=%h cond=%h dst_addr=%h psr=%b want all 0",
                        op_valid, dst, src, oper, func, cond, dst_addr, psr_read); end
    issue(16'h0330);
    n_cmp++; if (op_valid !== 1'b1 || dst !== 16'h0000 || func !== 4'h3) begin
      n_bad++; $display("FAIL reset_reg_clear: op_valid=%b dst=%h func=%h want 1 0000 3", op_valid, dst, func); end
  endtask

  task automatic test_reset_mid();
    write_reg(4'd9, 16'h9999);
    reset = 1'b1; instr_valid = 1'b1; instr = 16'h0909;
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h5555;
    psr_valid = 1'b1; psr_wr_en = 5'b11111; psr_wr = 5'b11111;
    tick();
    reset = 1'b0; idle();
    n_cmp++; if (op_valid !== 1'b0 || dst !== 16'h0 || psr_read !== 5'b0) begin
      n_bad++; $display("FAIL reset_mid: op_valid=%b dst=%h psr=%b want 0 0000 00000", op_valid, dst, psr_read); end
    issue(16'h0909);
    n_cmp++; if (dst !== 16'h0000 || src !== 16'h0000) begin
      n_bad++; $display("FAIL reset_mid_wb_dropped: dst=%h src=%h want 0000 0000", dst, src); end
  endtask

  task automatic test_sign_imm();
    write_reg(4'd2, 16'h0005);
    issue(16'h52FF);
    n_cmp++; if (dst !== 16'h0005 || src !== 16'hFFFF || oper !== 4'h5 || dst_addr !== 4'h2 ||
                 cond !== 4'h2 || func !== 4'hF || op_valid !== 1'b1) begin
      n_bad++; $display("FAIL sign_imm: dst=%h src=%h oper=%h dst_addr=%h cond=%h func=%h op_valid=%b want 0005 ffff 5 2 2 f 1",
                        dst, src, oper, dst_addr, cond, func, op_valid); end
    issue(16'h5271);
    n_cmp++; if (src !== 16'h0071) begin n_bad++; $display("FAIL sign_imm_pos: src=%h want 0071", src); end
  endtask

  task automatic test_zero_imm();
    write_reg(4'd4, 16'h0F0F);
    issue(16'h1480);
    n_cmp++; if (src !== 16'h0080 || dst !== 16'h0F0F || oper !== 4'h1) begin
      n_bad++; $display("FAIL zero_imm: src=%h dst=%h oper=%h want 0080 0f0f 1", src, dst, oper); end
    issue(16'h34FE);
    n_cmp++; if (src !== 16'h00FE) begin n_bad++; $display("FAIL zero_imm_xori: src=%h want 00fe", src); end
  endtask

  task automatic test_shift_imm();
    write_reg(4'd1, 16'hA5A5);
    issue(16'h811F);
    n_cmp++; if (src !== 16'hFFFF || dst !== 16'hA5A5) begin
      n_bad++; $display("FAIL shift_neg: src=%h dst=%h want ffff a5a5", src, dst); end
    issue(16'h81EF);
    n_cmp++; if (src !== 16'h000F) begin n_bad++; $display("FAIL shift_pos: src=%h want 000f", src); end
  endtask

  task automatic test_reg_reg();
    write_reg(4'd5, 16'h1111);
    write_reg(4'd6, 16'h2222);
    issue(16'h0506);
    n_cmp++; if (dst !== 16'h1111 || src !== 16'h2222) begin
      n_bad++; $display("FAIL reg_reg: dst=%h src=%h want 1111 2222", dst, src); end
    issue(16'h4506);
    n_cmp++; if (dst !== 16'h1111 || src !== 16'h2222 || oper !== 4'h4) begin
      n_bad++; $display("FAIL op4_reg: dst=%h src=%h oper=%h want 1111 2222 4", dst, src, oper); end
    pc = 16'h0340;
    issue(16'h45C6);
    n_cmp++; if (dst !== 16'h0340 || src !== 16'h2222 || func !== 4'hC) begin
      n_bad++; $display("FAIL jcond: dst=%h src=%h func=%h want 0340 2222 c", dst, src, func); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_v;
`ifdef OPERAND_BYPASS_EN
    exp_v = 16'hBEEF;
`else
    exp_v = 16'h0707;
`endif
    write_reg(4'd7, 16'h0707);
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'hBEEF;
    issue(16'h0757);
    wb_en = 1'b0;
    n_cmp++; if (dst !== exp_v || src !== exp_v) begin
      n_bad++; $display("FAIL bypass: dst=%h src=%h want %h %h", dst, src, exp_v, exp_v); end
    issue(16'h0757);
    n_cmp++; if (dst !== 16'hBEEF || src !== 16'hBEEF) begin
      n_bad++; $display("FAIL wb_visible: dst=%h src=%h want beef beef", dst, src); end
  endtask

  task automatic test_psr();
    psr_valid = 1'b1; psr_wr_en = 5'b00011; psr_wr = 5'b11111;
    tick(); idle();
    n_cmp++; if (psr_read !== 5'b00011) begin n_bad++; $display("FAIL psr_write: got %b want 00011", psr_read); end
    psr_valid = 1'b0; psr_wr_en = 5'b11111; psr_wr = 5'b11111;
    tick(); idle();
    n_cmp++; if (psr_read !== 5'b00011) begin n_bad++; $display("FAIL psr_unqualified: got %b want 00011", psr_read); end
    psr_valid = 1'b1; psr_wr_en = 5'b00001; psr_wr = 5'b00000;
    tick(); idle();
    n_cmp++; if (psr_read !== 5'b00010) begin n_bad++; $display("FAIL psr_partial: got %b want 00010", psr_read); end
  endtask

  task automatic test_stall_branch();
    logic [15:0] stall_instr [3];
    stall_instr[0] = 16'h52FF; stall_instr[1] = 16'hC0F0; stall_instr[2] = 16'h0000;
    issue(16'h0506);
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; instr_valid = 1'b1; instr = stall_instr[k];
      if (k == 0) begin wb_en = 1'b1; wb_addr = 4'd8; wb_data = 16'h8888; end
      if (k == 1) begin psr_valid = 1'b1; psr_wr_en = 5'b11111; psr_wr = 5'b10101; end
      tick(); idle();
      n_cmp++; if (op_valid !== 1'b1 || dst !== 16'h1111 || src !== 16'h2222 || oper !== 4'h0 || dst_addr !== 4'h5) begin
        n_bad++; $display("FAIL stall_hold[%0d]: op_valid=%b dst=%h src=%h oper=%h dst_addr=%h want 1 1111 2222 0 5",
                          k, op_valid, dst, src, oper, dst_addr); end
    end
    n_cmp++; if (psr_read !== 5'b10101) begin n_bad++; $display("FAIL stall_psr: got %b want 10101", psr_read); end
    pc = 16'h0100;
    issue(16'hC0F0);
    n_cmp++; if (dst !== 16'h0100 || src !== 16'hFFF0 || cond !== 4'h0 || oper !== 4'hC || func !== 4'hF) begin
      n_bad++; $display("FAIL branch: dst=%h src=%h cond=%h oper=%h func=%h want 0100 fff0 0 c f",
                        dst, src, cond, oper, func); end
    issue(16'h0808);
    n_cmp++; if (dst !== 16'h8888 || src !== 16'h8888) begin
      n_bad++; $display("FAIL stall_wb: dst=%h src=%h want 8888 8888", dst, src); end
  endtask

  task automatic test_empty();
    tick();
    n_cmp++; if (op_valid !== 1'b0 || dst !== 16'h8888 || dst_addr !== 4'h8) begin
      n_bad++; $display("FAIL empty: op_valid=%b dst=%h dst_addr=%h want 0 8888 8", op_valid, dst, dst_addr); end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = 16'h52FF; tick();
    n_cmp++; if (op_valid !== 1'b1 || dst !== 16'h0005 || src !== 16'hFFFF) begin
      n_bad++; $display("FAIL b2b_0: op_valid=%b dst=%h src=%h want 1 0005 ffff", op_valid, dst, src); end
    instr = 16'h1480; tick();
    n_cmp++; if (dst !== 16'h0F0F || src !== 16'h0080 || oper !== 4'h1) begin
      n_bad++; $display("FAIL b2b_1: dst=%h src=%h oper=%h want 0f0f 0080 1", dst, src, oper); end
    instr = 16'h0506; tick(); instr_valid = 1'b0;
    n_cmp++; if (dst !== 16'h1111 || src !== 16'h2222 || dst_addr !== 4'h5) begin
      n_bad++; $display("FAIL b2b_2: dst=%h src=%h dst_addr=%h want 1111 2222 5", dst, src, dst_addr); end
  endtask

  initial begin
    reset = 1'b1; instr = '0; pc = '0; wb_addr = '0; wb_data = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_reset_mid();
    test_sign_imm();
    test_zero_imm();
    test_shift_imm();
    test_reg_reg();
    test_bypass();
    test_psr();
    test_stall_branch();
    test_empty();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
